// File: rtl/fcmp_pipe_pkg.sv
// Shared definitions for the FP32 compare/select pipe: op encodings, FP32 fields, stage payloads.
// Also holds the result-select function used by the output stage.
package fcmp_pipe_pkg;

    localparam logic [2:0] FOP_FEQ  = 3'd0;
    localparam logic [2:0] FOP_FLT  = 3'd1;
    localparam logic [2:0] FOP_FLE  = 3'd2;
    localparam logic [2:0] FOP_FMIN = 3'd3;
    localparam logic [2:0] FOP_FMAX = 3'd4;

    localparam int FP_W     = 32;
    localparam int FP_SIGN  = 31;
    localparam int FP_MAG_W = 31;

    typedef struct packed {
        logic [2:0]      op;
        logic [FP_W-1:0] x1;
        logic [FP_W-1:0] x2;
        logic            lt;
        logic            eq;
    } s1_t;

    typedef struct packed {
        logic            ill;
        logic [FP_W-1:0] data;
    } res_t;

    // FMIN on equality returns x2 and FMAX returns x1, which falls out of the lt-only select.
    function automatic res_t fcmp_select(input s1_t s);
        res_t r;
        r.ill  = 1'b0;
        r.data = '0;
        case (s.op)
            FOP_FEQ:  r.data = {{(FP_W-1){1'b0}}, s.eq};
            FOP_FLT:  r.data = {{(FP_W-1){1'b0}}, s.lt};
            FOP_FLE:  r.data = {{(FP_W-1){1'b0}}, s.lt | s.eq};
            FOP_FMIN: r.data = s.lt ? s.x1 : s.x2;
            FOP_FMAX: r.data = s.lt ? s.x2 : s.x1;
            default:  r.ill  = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fcmp_pipe_core.sv
// Combinational FP32 ordering on raw bit patterns: produces lt and eq, with +0 == -0.
// No NaN or denormal special-casing; sign/magnitude ordering only.
module fcmp_pipe_core
    import fcmp_pipe_pkg::*;
(
    input  logic [FP_W-1:0] x1_i,
    input  logic [FP_W-1:0] x2_i,
    output logic            lt_o,
    output logic            eq_o
);

    logic                s1;
    logic                s2;
    logic [FP_MAG_W-1:0] m1;
    logic [FP_MAG_W-1:0] m2;
    logic                both_zero;

    assign s1 = x1_i[FP_SIGN];
    assign s2 = x2_i[FP_SIGN];
    assign m1 = x1_i[FP_MAG_W-1:0];
    assign m2 = x2_i[FP_MAG_W-1:0];

    assign both_zero = (m1 == '0) && (m2 == '0);
    assign eq_o      = (x1_i == x2_i) | both_zero;

    // Two negatives order by reversed magnitude.
    assign lt_o = ~eq_o & ( (s1 & ~s2)
                          | (~s1 & ~s2 & (m1 < m2))
                          | (s1 & s2 & (m1 > m2)) );

endmodule

// File: rtl/fcmp_pipe.sv
// Two-stage FP32 compare/select (FEQ/FLT/FLE/FMIN/FMAX) between FPU issue and writeback.
// Latency 2 cycles, 1 op/cycle; in_ready = ~s1_valid | ~s2_valid | out_ready, outputs hold while stalled.
module fcmp_pipe
    import fcmp_pipe_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [FP_W-1:0]  in_x1,
    input  logic [FP_W-1:0]  in_x2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FP_W-1:0]  out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_ill,
    output logic             busy
);

    logic             s1_valid_q, s1_valid_d;
    s1_t              s1_q, s1_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    logic             s2_valid_q, s2_valid_d;
    logic [FP_W-1:0]  out_data_q, out_data_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             out_ill_q, out_ill_d;

    logic             s2_adv;
    logic             s1_adv;
    logic             accept;
    logic             cmp_lt;
    logic             cmp_eq;
    res_t             sel;

    fcmp_pipe_core u_core (
        .x1_i (in_x1),
        .x2_i (in_x2),
        .lt_o (cmp_lt),
        .eq_o (cmp_eq)
    );

    assign s2_adv   = ~s2_valid_q | out_ready;
    assign s1_adv   = s1_valid_q & s2_adv;
    assign in_ready = ~s1_valid_q | s2_adv;
    assign accept   = in_valid & in_ready;
    assign sel      = fcmp_select(s1_q);

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        out_data_d = out_data_q;
        out_tag_d  = out_tag_q;
        out_ill_d  = out_ill_q;

        // S1 empties when it hands over and nothing new arrives in the same cycle.
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_d.op    = in_op;
            s1_d.x1    = in_x1;
            s1_d.x2    = in_x2;
            s1_d.lt    = cmp_lt;
            s1_d.eq    = cmp_eq;
            s1_tag_d   = in_tag;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
        end

        if (s1_adv) begin
            out_data_d = sel.data;
            out_tag_d  = s1_tag_q;
            out_ill_d  = sel.ill;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            out_data_q <= '0;
            out_tag_q  <= '0;
            out_ill_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            out_data_q <= out_data_d;
            out_tag_q  <= out_tag_d;
            out_ill_q  <= out_ill_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign out_ill   = out_ill_q;
    assign busy      = s1_valid_q | s2_valid_q;

endmodule
